// File: rtl/ide_pkg.sv
// Shared types and default timing for the 68000-to-ATA PIO bus controller.
package ide_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_ACK,
    ST_ERR,
    ST_RECOVER
  } ide_state_e;

  // A[4] picks the register block: 0 = command block (CS0), 1 = control block (CS1).
  typedef enum logic {
    CS_SEL0 = 1'b0,
    CS_SEL1 = 1'b1
  } cs_sel_e;

  localparam logic [19:0] DEF_BASE_ADDR   = 20'h80040;
  localparam int          DEF_SETUP_CYC   = 2;
  localparam int          DEF_STROBE_CYC  = 4;
  localparam int          DEF_RECOVER_CYC = 3;
  localparam int          DEF_IORDY_TMO   = 255;
  localparam logic [2:0]  DEF_IRQ_LEVEL   = 3'd6;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ide_pio_ctrl_if.sv
// CPU-side and IDE-side signal bundle of the PIO controller.
interface ide_pio_ctrl_if;
  logic [19:1] A;
  logic [2:0]  FC;
  logic        IOSEL_n;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW;
  logic        IORDY;
  logic        IDECS0_n;
  logic        IDECS1_n;
  logic [2:0]  IDEDA;
  logic        IDERD_n;
  logic        IDEWR_n;
  logic        IDEBUFH_n;
  logic        IDEBUFL_n;
  logic        DTACK_n;
  logic        DTACK_OE;
  logic        BERR_n;
  logic        VPA_n;

  modport master (
    output A, FC, IOSEL_n, AS_n, UDS_n, LDS_n, RW, IORDY,
    input  IDECS0_n, IDECS1_n, IDEDA, IDERD_n, IDEWR_n, IDEBUFH_n, IDEBUFL_n,
           DTACK_n, DTACK_OE, BERR_n, VPA_n
  );

  modport slave (
    input  A, FC, IOSEL_n, AS_n, UDS_n, LDS_n, RW, IORDY,
    output IDECS0_n, IDECS1_n, IDEDA, IDERD_n, IDEWR_n, IDEBUFH_n, IDEBUFL_n,
           DTACK_n, DTACK_OE, BERR_n, VPA_n
  );
endinterface

// File: rtl/ide_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module ide_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ide_pio_ctrl.sv
// ATA PIO-mode cycle generator between the 68000 bus and the IDE port,
// with IORDY wait/timeout, DTACK/BERR generation and one autovectored IRQ level.
module ide_pio_ctrl
  import ide_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          SETUP_CYC   = DEF_SETUP_CYC,
  parameter int          STROBE_CYC  = DEF_STROBE_CYC,
  parameter int          RECOVER_CYC = DEF_RECOVER_CYC,
  parameter int          IORDY_TMO   = DEF_IORDY_TMO,
  parameter logic [2:0]  IRQ_LEVEL   = DEF_IRQ_LEVEL
) (
  input logic           CPUCLK,
  input logic           RESET,
  ide_pio_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, RECOVER_CYC, IORDY_TMO);
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(IORDY_TMO - 1);

  ide_state_e       state, state_nx;
  cs_sel_e          cs_sel;
  logic [2:0]       da_q;
  logic             rw_q, lane_h_q, lane_l_q;
  logic             cs_act_q, cs_act_nx;
  logic             strobe_q, strobe_nx;
  logic             dtack_q, dtack_nx;
  logic             dtack_oe_q, dtack_oe_nx;
  logic             berr_q, berr_nx;
  logic             cap;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] wcnt;
  logic             wcnt_clr, wcnt_inc;
  logic             sel, req;

  assign sel = (bus.FC != 3'b111) && !bus.IOSEL_n && (bus.A[19:5] == BASE_ADDR[19:5]);
  assign req = sel && !bus.AS_n && (!bus.UDS_n || !bus.LDS_n);

  ide_timer #(.W(CNT_W)) u_cnt (
    .clk      (CPUCLK),
    .rst      (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CPUCLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      cs_act_q   <= 1'b0;
      strobe_q   <= 1'b0;
      dtack_q    <= 1'b0;
      dtack_oe_q <= 1'b0;
      berr_q     <= 1'b0;
      cs_sel     <= CS_SEL0;
      da_q       <= '0;
      rw_q       <= 1'b1;
      lane_h_q   <= 1'b0;
      lane_l_q   <= 1'b0;
      wcnt       <= '0;
    end else begin
      state      <= state_nx;
      cs_act_q   <= cs_act_nx;
      strobe_q   <= strobe_nx;
      dtack_q    <= dtack_nx;
      dtack_oe_q <= dtack_oe_nx;
      berr_q     <= berr_nx;
      if (cap) begin
        cs_sel   <= cs_sel_e'(bus.A[4]);
        da_q     <= bus.A[3:1];
        rw_q     <= bus.RW;
        lane_h_q <= !bus.UDS_n;
        lane_l_q <= !bus.LDS_n;
      end
      if (wcnt_clr) begin
        wcnt <= '0;
      end else if (wcnt_inc && (wcnt != WAIT_LAST)) begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cs_act_nx   = cs_act_q;
    strobe_nx   = strobe_q;
    dtack_nx    = dtack_q;
    dtack_oe_nx = dtack_oe_q;
    berr_nx     = berr_q;
    cap         = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    wcnt_clr    = 1'b0;
    wcnt_inc    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req) begin
          cap       = 1'b1;
          cs_act_nx = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = SETUP_LD;
          state_nx  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (bus.AS_n) begin
          cnt_load = 1'b1;
          cnt_val  = RECOVER_LD;
          state_nx = ST_RECOVER;
        end else if (cnt_zero) begin
          strobe_nx = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = STROBE_LD;
          wcnt_clr  = 1'b1;
          state_nx  = ST_STROBE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        // An aborted CPU cycle wins over completion on the same edge.
        if (bus.AS_n) begin
          strobe_nx = 1'b0;
          cnt_load  = 1'b1;
          cnt_val   = RECOVER_LD;
          state_nx  = ST_RECOVER;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (bus.IORDY) begin
          dtack_nx    = 1'b1;
          dtack_oe_nx = 1'b1;
          state_nx    = ST_ACK;
        end else if (wcnt == WAIT_LAST) begin
          strobe_nx = 1'b0;
          berr_nx   = 1'b1;
          state_nx  = ST_ERR;
        end else begin
          wcnt_inc = 1'b1;
        end
      end
      ST_ACK: begin
        // DTACK is driven high for one cycle before the driver is released.
        if (bus.AS_n) begin
          strobe_nx = 1'b0;
          dtack_nx  = 1'b0;
          cnt_load  = 1'b1;
          cnt_val   = RECOVER_LD;
          state_nx  = ST_RECOVER;
        end
      end
      ST_ERR: begin
        if (bus.AS_n) begin
          berr_nx  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = RECOVER_LD;
          state_nx = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        dtack_oe_nx = 1'b0;
        if (cnt_zero) begin
          cs_act_nx = 1'b0;
          state_nx  = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.IDECS0_n  = !(cs_act_q && (cs_sel == CS_SEL0));
  assign bus.IDECS1_n  = !(cs_act_q && (cs_sel == CS_SEL1));
  assign bus.IDEDA     = da_q;
  assign bus.IDERD_n   = !(strobe_q && rw_q);
  assign bus.IDEWR_n   = !(strobe_q && !rw_q);
  assign bus.IDEBUFH_n = !(strobe_q && lane_h_q);
  assign bus.IDEBUFL_n = !(strobe_q && lane_l_q);
  assign bus.DTACK_n   = !dtack_q;
  assign bus.DTACK_OE  = dtack_oe_q;
  assign bus.BERR_n    = !berr_q;
  assign bus.VPA_n     = !((bus.FC == 3'b111) && !bus.AS_n && (bus.A[3:1] == IRQ_LEVEL));

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Self-checking bench for ide_pio_ctrl: each transfer is predicted cycle by cycle
// from the timing rules (setup, strobe, IORDY wait/timeout, ack/err, recovery).
module tb_ide_pio_ctrl;

  localparam logic [19:0] BASE = 20'h80040;
  localparam int S   = 2;
  localparam int STB = 4;
  localparam int R   = 3;
  localparam int TMO = 255;
  localparam logic [2:0] IRQ = 3'd6;
  localparam logic [9:0] IDLE_V = 10'b1111111011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ide_pio_ctrl_if bus ();

  ide_pio_ctrl #(
    .BASE_ADDR   (BASE),
    .SETUP_CYC   (S),
    .STROBE_CYC  (STB),
    .RECOVER_CYC (R),
    .IORDY_TMO   (TMO),
    .IRQ_LEVEL   (IRQ)
  ) dut (
    .CPUCLK (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.IDECS0_n, bus.IDECS1_n, bus.IDERD_n, bus.IDEWR_n, bus.IDEBUFH_n,
            bus.IDEBUFL_n, bus.DTACK_n, bus.DTACK_OE, bus.BERR_n, bus.VPA_n};
  endfunction

  // Cycle in which the cycle reaches ACK (IORDY seen) or ERR (timeout), counted from the req cycle.
  function automatic int term_of(input int n);
    return (n < TMO) ? (S + STB + 1 + n) : (S + STB + TMO);
  endfunction

  task automatic idle_bus();
    bus.A       = {BASE[19:5], 4'h0};
    bus.FC      = 3'd5;
    bus.IOSEL_n = 1'b0;
    bus.AS_n    = 1'b1;
    bus.UDS_n   = 1'b1;
    bus.LDS_n   = 1'b1;
    bus.RW      = 1'b1;
    bus.IORDY   = 1'b1;
  endtask

  // One CPU access: n = IORDY-low cycles at end of strobe (>=TMO means never ready),
  // abort_at > 0 releases AS_n in that cycle, otherwise AS_n is held 'hold' cycles past ACK/ERR.
  // chain re-asserts AS_n in the final recovery cycle so the next access follows immediately.
  task automatic run_xfer(input string nm, input logic [3:0] lo, input bit rw, input bit uds,
                          input bit lds, input int n, input int abort_at, input int hold,
                          input bit chain);
    int z, term, rel, last, stb_end;
    bit ack, done, cs, stb, dt, oe, be;
    logic [9:0] exp_v, act_v;
    z    = S + STB;
    ack  = (n < TMO);
    term = term_of(n);
    rel  = (abort_at > 0) ? abort_at : term + hold;
    last = rel + R;
    done = (rel >= term);
    stb_end = (!ack && done) ? term - 1 : rel;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      cs  = (k >= 1) && (k <= rel + R);
      stb = (k >= S + 1) && (k <= stb_end);
      dt  = ack && done && (k >= term) && (k <= rel);
      oe  = ack && done && (k >= term) && (k <= rel + 1);
      be  = !ack && done && (k >= term) && (k <= rel);
      exp_v = {!(cs && !lo[3]), !(cs && lo[3]), !(stb && rw), !(stb && !rw),
               !(stb && !uds), !(stb && !lds), !dt, oe, !be, 1'b1};
      act_v = outs();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s k=%0d outputs cs0,cs1,rd,wr,bh,bl,dtk,oe,berr,vpa got %b want %b",
                 nm, k, act_v, exp_v);
      end
      if (cs) begin
        checks++;
        if (bus.IDEDA !== lo[2:0]) begin
          errors++;
          $display("FAIL %s k=%0d IDEDA got %0d want %0d", nm, k, bus.IDEDA, lo[2:0]);
        end
      end
      bus.A     = {BASE[19:5], lo};
      bus.FC    = 3'd5;
      bus.RW    = rw;
      bus.UDS_n = uds;
      bus.LDS_n = lds;
      bus.AS_n  = (k >= rel) && !(chain && (k == last));
      bus.IORDY = ack && (k >= z + n);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== IDLE_V || bus.IDEDA !== 3'd0) begin
      errors++;
      $display("FAIL reset outputs got %b/%0d want %b/0", outs(), bus.IDEDA, IDLE_V);
    end
    rst = 1'b0;
  endtask

  task automatic test_word_read();
    run_xfer("word_read", 4'h0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 1'b0);
  endtask

  task automatic test_byte_write();
    run_xfer("byte_write", {1'b1, 3'd6}, 1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b0);
  endtask

  task automatic test_iordy();
    run_xfer("iordy_stretch", 4'h3, 1'b1, 1'b0, 1'b1, 10, 0, 0, 1'b0);
    run_xfer("iordy_timeout", 4'h7, 1'b1, 1'b0, 1'b0, TMO, 0, 2, 1'b0);
  endtask

  task automatic test_reset_in_strobe();
    for (int k = 0; k <= S + 2; k++) begin
      @(negedge clk);
      if (k == S + 2) begin
        checks++;
        if (bus.IDERD_n !== 1'b0 || bus.IDECS0_n !== 1'b0) begin
          errors++;
          $display("FAIL rst_strobe pre rd/cs got %b%b want 00", bus.IDERD_n, bus.IDECS0_n);
        end
      end
      bus.A     = {BASE[19:5], 4'h2};
      bus.RW    = 1'b1;
      bus.UDS_n = 1'b0;
      bus.LDS_n = 1'b0;
      bus.AS_n  = 1'b0;
      bus.IORDY = 1'b1;
    end
    #2;
    rst = 1'b1;
    bus.AS_n = 1'b1;
    #1;
    checks++;
    if (outs() !== IDLE_V) begin
      errors++;
      $display("FAIL rst_strobe async outputs got %b want %b", outs(), IDLE_V);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== IDLE_V) begin
      errors++;
      $display("FAIL rst_strobe after release got %b want %b", outs(), IDLE_V);
    end
  endtask

  task automatic test_abort();
    run_xfer("abort_setup", 4'h1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b0);
    run_xfer("abort_strobe", 4'h9, 1'b0, 1'b0, 1'b0, 0, S + 2, 0, 1'b0);
    run_xfer("abort_wait", 4'h4, 1'b1, 1'b0, 1'b0, 20, S + STB + 5, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_0", 4'h5, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    run_xfer("b2b_1", 4'hA, 1'b0, 1'b0, 1'b1, 1, 0, 1, 1'b1);
    run_xfer("b2b_2", 4'h2, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_vpa();
    @(negedge clk);
    bus.FC = 3'b111;
    bus.A  = {BASE[19:5], 1'b0, 3'd6};
    bus.UDS_n = 1'b0;
    bus.LDS_n = 1'b0;
    bus.AS_n  = 1'b0;
    #1;
    checks++;
    if (bus.VPA_n !== 1'b0) begin
      errors++;
      $display("FAIL vpa_level6 got %b want 0", bus.VPA_n);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (outs() !== 10'b1111111010) begin
      errors++;
      $display("FAIL vpa_no_ide outputs got %b want 1111111010", outs());
    end
    bus.A = {BASE[19:5], 1'b0, 3'd5};
    #1;
    checks++;
    if (bus.VPA_n !== 1'b1) begin
      errors++;
      $display("FAIL vpa_level5 got %b want 1", bus.VPA_n);
    end
    bus.FC      = 3'd5;
    bus.IOSEL_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (outs() !== IDLE_V) begin
      errors++;
      $display("FAIL iosel_off outputs got %b want %b", outs(), IDLE_V);
    end
    bus.AS_n    = 1'b1;
    bus.IOSEL_n = 1'b0;
  endtask

  task automatic test_random();
    int n, ab, hd;
    logic [3:0] lo;
    logic [1:0] lanes;
    bit rw, ch;
    for (int i = 0; i < 30; i++) begin
      lo    = 4'($urandom_range(0, 15));
      lanes = 2'($urandom_range(1, 3));
      rw    = 1'($urandom_range(0, 1));
      n     = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 12);
      hd    = $urandom_range(0, 3);
      ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, term_of(n) - 1) : 0;
      ch    = 1'($urandom_range(0, 1));
      run_xfer("random", lo, rw, !lanes[1], !lanes[0], n, ab, hd, ch);
    end
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_word_read();
    test_byte_write();
    test_iordy();
    test_reset_in_strobe();
    test_abort();
    test_back_to_back();
    test_vpa();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
